// File: rtl/stream_aligner_pkg.sv
// Shared widths, FSM encoding and beat-length helper for the stream aligner.
package stream_aligner_pkg;

    localparam int IN_WIDTH   = 272;
    localparam int OUT_WIDTH  = 256;
    localparam int LEN_WIDTH  = 8;
    localparam int HDR_WIDTH  = 16;
    localparam int ACC_WIDTH  = OUT_WIDTH + IN_WIDTH;
    localparam int FILL_WIDTH = $clog2(ACC_WIDTH + 1);
    localparam int BITS_WIDTH = $clog2(OUT_WIDTH + 1);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_e;

    typedef struct packed {
        logic [FILL_WIDTH-1:0] nbits;
        logic                  over;
    } beat_len_t;

    // Header plus payload bytes; the sum is formed at 32 bits so a large
    // in_len cannot wrap before the clamp to IN_WIDTH.
    function automatic beat_len_t len_to_bits(input logic [LEN_WIDTH-1:0] len);
        beat_len_t   res;
        logic [31:0] raw;
        raw = 32'(HDR_WIDTH) + (32'(len) << 2'd3);
        if (raw > 32'(IN_WIDTH)) begin
            res.nbits = FILL_WIDTH'(IN_WIDTH);
            res.over  = 1'b1;
        end else begin
            res.nbits = FILL_WIDTH'(raw);
            res.over  = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/stream_aligner_if.sv
// Beat input / word output handshake bundle of the stream aligner.
interface stream_aligner_if;
    import stream_aligner_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [IN_WIDTH-1:0]   in_data;
    logic [LEN_WIDTH-1:0]  in_len;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [OUT_WIDTH-1:0]  out_data;
    logic                  out_last;
    logic [BITS_WIDTH-1:0] out_bits;
    logic [FILL_WIDTH-1:0] fill_level;
    logic                  err;

    modport master (
        output in_valid, in_data, in_len, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_bits, fill_level, err
    );

    modport slave (
        input  in_valid, in_data, in_len, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_bits, fill_level, err
    );

endinterface

// File: rtl/stream_aligner_appender.sv
// Combinational splice of one beat into the accumulator at the current fill offset.
module bit_appender
    import stream_aligner_pkg::*;
(
    input  logic [ACC_WIDTH-1:0]  acc_i,
    input  logic [FILL_WIDTH-1:0] fill_i,
    input  logic [IN_WIDTH-1:0]   data_i,
    input  logic [FILL_WIDTH-1:0] nbits_i,
    output logic [ACC_WIDTH-1:0]  acc_o,
    output logic [FILL_WIDTH-1:0] fill_o
);

    logic [IN_WIDTH-1:0] keep_s;

    // Drop beat bits above nbits, then OR the beat in above the held bits.
    always_comb begin
        keep_s = ~({IN_WIDTH{1'b1}} << nbits_i);
        acc_o  = acc_i | ({{OUT_WIDTH{1'b0}}, data_i & keep_s} << fill_i);
        fill_o = fill_i + nbits_i;
    end

endmodule

// File: rtl/stream_aligner.sv
// Packs variable-length beats into fixed OUT_WIDTH words, with end-of-stream flush.
module stream_aligner
    import stream_aligner_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    stream_aligner_if.slave  bus
);

    state_e                state_q, state_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [FILL_WIDTH-1:0] fill_q, fill_d;
    logic                  err_q, err_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic [OUT_WIDTH-1:0]  out_data_q, out_data_d;
    logic                  out_last_q, out_last_d;
    logic [BITS_WIDTH-1:0] out_bits_q, out_bits_d;

    beat_len_t             beat_s;
    logic [ACC_WIDTH-1:0]  app_acc_s;
    logic [FILL_WIDTH-1:0] app_fill_s;
    logic [FILL_WIDTH-1:0] take_s;
    logic                  accept_s;
    logic                  drain_s;
    logic                  flush_end_s;

    assign beat_s      = len_to_bits(bus.in_len);
    assign accept_s    = bus.in_valid && in_ready_q;
    assign take_s      = (fill_q > FILL_WIDTH'(OUT_WIDTH)) ? FILL_WIDTH'(OUT_WIDTH) : fill_q;
    assign flush_end_s = (state_q == FLUSH) && (fill_q <= FILL_WIDTH'(OUT_WIDTH));
    assign drain_s     = ((fill_q >= FILL_WIDTH'(OUT_WIDTH)) ||
                          ((state_q == FLUSH) && (fill_q != {FILL_WIDTH{1'b0}})))
                         && (!out_valid_q || bus.out_ready);

    bit_appender u_appender (
        .acc_i   (acc_q),
        .fill_i  (fill_q),
        .data_i  (bus.in_data),
        .nbits_i (beat_s.nbits),
        .acc_o   (app_acc_s),
        .fill_o  (app_fill_s)
    );

    // State and output registers; reset discards any partially packed word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            acc_q       <= {ACC_WIDTH{1'b0}};
            fill_q      <= {FILL_WIDTH{1'b0}};
            err_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= {OUT_WIDTH{1'b0}};
            out_last_q  <= 1'b0;
            out_bits_q  <= {BITS_WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            fill_q      <= fill_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_bits_q  <= out_bits_d;
        end
    end

    // Next state: accept and drain never coincide, since accept needs fill below a word.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        fill_d  = fill_q;
        err_d   = err_q;
        if (accept_s) begin
            acc_d  = app_acc_s;
            fill_d = app_fill_s;
            err_d  = err_q | beat_s.over;
            if (bus.in_last) begin
                state_d = FLUSH;
            end else begin
                state_d = state_q;
            end
        end else if (drain_s) begin
            acc_d  = acc_q >> OUT_WIDTH;
            fill_d = fill_q - take_s;
            if (flush_end_s) begin
                state_d = RUN;
            end else begin
                state_d = state_q;
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // Output word register and the registered in_ready derived from next state.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_bits_d  = out_bits_q;
        in_ready_d  = (state_d == RUN) && (fill_d < FILL_WIDTH'(OUT_WIDTH));
        if (drain_s) begin
            out_valid_d = 1'b1;
            out_data_d  = acc_q[OUT_WIDTH-1:0] & ~({OUT_WIDTH{1'b1}} << fill_q);
            out_bits_d  = BITS_WIDTH'(take_s);
            out_last_d  = flush_end_s;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_last   = out_last_q;
    assign bus.out_bits   = out_bits_q;
    assign bus.fill_level = fill_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_stream_aligner.sv
// Bench for stream_aligner: bit-queue reference model, directed cases and random traffic.
module tb_stream_aligner;
    import stream_aligner_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    stream_aligner_if bif ();

    stream_aligner dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    // Reference model: the accumulator is a plain queue of bits, LSB first.
    bit             mq[$];
    bit             m_flush, m_err, m_ov, m_olast, m_inrdy;
    logic [255:0]   m_odata;
    int             m_obits;

    task automatic chk(input string name, input logic [IN_WIDTH-1:0] act,
                       input logic [IN_WIDTH-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [IN_WIDTH-1:0] rnd_data();
        logic [287:0] t;
        for (int k = 0; k < 9; k++) t[k*32 +: 32] = $urandom;
        return t[IN_WIDTH-1:0];
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_flush = 1'b0; m_err = 1'b0; m_ov = 1'b0; m_olast = 1'b0;
        m_inrdy = 1'b0; m_odata = 256'd0; m_obits = 0;
    endfunction

    function automatic void model_step();
        int nb;
        int sz;
        int take;
        bit acc_ok;
        bit drain;
        sz     = mq.size();
        acc_ok = bif.in_valid && m_inrdy;
        drain  = (sz >= OUT_WIDTH || (m_flush && sz > 0)) && (!m_ov || bif.out_ready);
        if (acc_ok) begin
            nb = HDR_WIDTH + 8 * int'(bif.in_len);
            if (nb > IN_WIDTH) begin
                nb    = IN_WIDTH;
                m_err = 1'b1;
            end
            for (int i = 0; i < nb; i++) mq.push_back(bif.in_data[i]);
            if (bif.in_last) m_flush = 1'b1;
        end else if (drain) begin
            take    = (sz < OUT_WIDTH) ? sz : OUT_WIDTH;
            m_odata = 256'd0;
            for (int i = 0; i < take; i++) m_odata[i] = mq.pop_front();
            m_obits = take;
            m_olast = m_flush && (sz <= OUT_WIDTH);
            if (m_olast) m_flush = 1'b0;
        end
        if (drain) m_ov = 1'b1;
        else if (bif.out_ready) m_ov = 1'b0;
        m_inrdy = !m_flush && (mq.size() < OUT_WIDTH);
    endfunction

    // Every cycle out of reset, the DUT must match the model on all outputs.
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("in_ready",   IN_WIDTH'(bif.in_ready),   IN_WIDTH'(m_inrdy));
            chk("out_valid",  IN_WIDTH'(bif.out_valid),  IN_WIDTH'(m_ov));
            chk("out_data",   IN_WIDTH'(bif.out_data),   IN_WIDTH'(m_odata));
            chk("out_last",   IN_WIDTH'(bif.out_last),   IN_WIDTH'(m_olast));
            chk("out_bits",   IN_WIDTH'(bif.out_bits),   IN_WIDTH'(m_obits));
            chk("fill_level", IN_WIDTH'(bif.fill_level), IN_WIDTH'(mq.size()));
            chk("err",        IN_WIDTH'(bif.err),        IN_WIDTH'(m_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic send_beat(input logic [IN_WIDTH-1:0] d, input int len, input bit last);
        bit ok;
        ok           = 1'b0;
        bif.in_data  = d;
        bif.in_len   = LEN_WIDTH'(len);
        bif.in_last  = last;
        bif.in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            ok = bif.in_ready;
            tick();
        end
        chk("beat_accepted", IN_WIDTH'(ok), IN_WIDTH'(1));
        bif.in_valid = 1'b0;
        bif.in_last  = 1'b0;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 20 && !bif.out_valid; i++) tick();
        chk("out_valid_wait", IN_WIDTH'(bif.out_valid), IN_WIDTH'(1));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"},  IN_WIDTH'(bif.in_ready),   '0);
        chk({tag, "_out_valid"}, IN_WIDTH'(bif.out_valid),  '0);
        chk({tag, "_out_data"},  IN_WIDTH'(bif.out_data),   '0);
        chk({tag, "_out_last"},  IN_WIDTH'(bif.out_last),   '0);
        chk({tag, "_out_bits"},  IN_WIDTH'(bif.out_bits),   '0);
        chk({tag, "_fill"},      IN_WIDTH'(bif.fill_level), '0);
        chk({tag, "_err"},       IN_WIDTH'(bif.err),        '0);
    endtask

    logic [IN_WIDTH-1:0]  a, b, c, d, e, f, g;
    logic [OUT_WIDTH-1:0] od;

    initial begin
        bif.in_valid  = 1'b0;
        bif.in_data   = '0;
        bif.in_len    = '0;
        bif.in_last   = 1'b0;
        bif.out_ready = 1'b1;
        model_reset();

        // Reset held with random inputs
        repeat (4) begin
            @(posedge clk); #1;
            bif.in_valid  = 1'($urandom);
            bif.in_data   = rnd_data();
            bif.in_len    = LEN_WIDTH'($urandom);
            bif.in_last   = 1'($urandom);
            bif.out_ready = 1'($urandom);
        end
        chk_all_zero("reset");
        bif.in_valid  = 1'b0;
        bif.in_last   = 1'b0;
        bif.out_ready = 1'b1;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        tick();
        chk("post_reset_in_ready", IN_WIDTH'(bif.in_ready),   IN_WIDTH'(1));
        chk("post_reset_fill",     IN_WIDTH'(bif.fill_level), IN_WIDTH'(0));

        // Two 128-bit beats form one word
        a = rnd_data();
        b = rnd_data();
        send_beat(a, 14, 1'b0);
        send_beat(b, 14, 1'b0);
        wait_valid();
        chk("pair_data", IN_WIDTH'(bif.out_data), IN_WIDTH'({b[127:0], a[127:0]}));
        chk("pair_bits", IN_WIDTH'(bif.out_bits), IN_WIDTH'(256));
        chk("pair_last", IN_WIDTH'(bif.out_last), IN_WIDTH'(0));
        chk("pair_fill", IN_WIDTH'(bif.fill_level), IN_WIDTH'(0));
        tick();

        // Exactly-full beat drains one cycle after acceptance
        c = rnd_data();
        send_beat(c, 30, 1'b0);
        chk("full_fill_after_accept",  IN_WIDTH'(bif.fill_level), IN_WIDTH'(256));
        chk("full_valid_after_accept", IN_WIDTH'(bif.out_valid),  IN_WIDTH'(0));
        tick();
        chk("full_valid_next", IN_WIDTH'(bif.out_valid),  IN_WIDTH'(1));
        chk("full_fill_next",  IN_WIDTH'(bif.fill_level), IN_WIDTH'(0));
        chk("full_data",       IN_WIDTH'(bif.out_data),   IN_WIDTH'(c[255:0]));
        tick();

        // Stream end on an exact word boundary
        d = rnd_data();
        send_beat(d, 30, 1'b1);
        tick();
        chk("exact_last", IN_WIDTH'(bif.out_last), IN_WIDTH'(1));
        chk("exact_bits", IN_WIDTH'(bif.out_bits), IN_WIDTH'(256));
        chk("exact_in_ready", IN_WIDTH'(bif.in_ready), IN_WIDTH'(1));
        tick();

        // Backpressure while streaming 128-bit beats
        bif.out_ready = 1'b0;
        bif.in_len    = LEN_WIDTH'(14);
        bif.in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bif.in_data = rnd_data();
            tick();
        end
        bif.in_valid = 1'b0;
        chk("bp_in_ready", IN_WIDTH'(bif.in_ready),   IN_WIDTH'(0));
        chk("bp_fill",     IN_WIDTH'(bif.fill_level), IN_WIDTH'(256));
        bif.out_ready = 1'b1;
        repeat (20) tick();

        // Flush of 456 bits: one full word then a 200-bit padded last word
        e = rnd_data();
        f = rnd_data();
        send_beat(e, 30, 1'b0);
        wait_valid();
        chk("flush_w1_last", IN_WIDTH'(bif.out_last), IN_WIDTH'(0));
        chk("flush_w1_data", IN_WIDTH'(bif.out_data), IN_WIDTH'(e[255:0]));
        send_beat(f, 23, 1'b1);
        wait_valid();
        od = bif.out_data;
        chk("flush_w2_bits", IN_WIDTH'(bif.out_bits), IN_WIDTH'(200));
        chk("flush_w2_last", IN_WIDTH'(bif.out_last), IN_WIDTH'(1));
        chk("flush_w2_pad",  IN_WIDTH'(od[255:200]),  IN_WIDTH'(0));
        chk("flush_w2_data", IN_WIDTH'(od[199:0]),    IN_WIDTH'(f[199:0]));
        chk("flush_in_ready", IN_WIDTH'(bif.in_ready), IN_WIDTH'(1));
        tick();

        // Oversized beat clamps and sets err; then reset mid-flush
        g = rnd_data();
        send_beat(g, 40, 1'b0);
        chk("err_set",     IN_WIDTH'(bif.err),        IN_WIDTH'(1));
        chk("err_clamped", IN_WIDTH'(bif.fill_level), IN_WIDTH'(272));
        tick();
        send_beat(rnd_data(), 0, 1'b1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_all_zero("midflush_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        chk("rerun_in_ready", IN_WIDTH'(bif.in_ready), IN_WIDTH'(1));

        // Random traffic against the model
        for (int cyc = 0; cyc < 2000; cyc++) begin
            bif.in_valid = ($urandom_range(0, 3) != 0);
            bif.in_data  = rnd_data();
            if ($urandom_range(0, 9) == 0) bif.in_len = LEN_WIDTH'($urandom_range(0, 255));
            else bif.in_len = LEN_WIDTH'($urandom_range(0, 34));
            bif.in_last   = ($urandom_range(0, 15) == 0);
            bif.out_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        bif.in_valid  = 1'b0;
        bif.in_last   = 1'b0;
        bif.out_ready = 1'b1;
        repeat (40) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
